// File: rtl/cdb_arbiter_if.sv
// Common data bus bundle: functional-unit requests and grants, plus the broadcast result.
// The requester side uses the master modport; the arbiter uses the slave modport.
interface cdb_arbiter_if #(
  parameter int num_req    = 4,
  parameter int data_width = 16,
  parameter int tag_width  = 3
);
  localparam int src_width = $clog2(num_req);

  logic [num_req-1:0]            req_valid;
  logic [num_req-1:0]            req_urgent;
  logic [num_req*tag_width-1:0]  req_tag;
  logic [num_req*data_width-1:0] req_data;
  logic [num_req-1:0]            req_grant;
  logic                          cdb_valid;
  logic [tag_width-1:0]          cdb_tag;
  logic [data_width-1:0]         cdb_data;
  logic [src_width-1:0]          cdb_src;

  modport master (
    output req_valid, req_urgent, req_tag, req_data,
    input  req_grant, cdb_valid, cdb_tag, cdb_data, cdb_src
  );

  modport slave (
    input  req_valid, req_urgent, req_tag, req_data,
    output req_grant, cdb_valid, cdb_tag, cdb_data, cdb_src
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter: urgent-first candidate set, rotating pointer, one-cycle
// registered broadcast of the winner's tag/data/index, cancelled by flush or reset.
module cdb_arbiter #(
  parameter int num_req    = 4,
  parameter int data_width = 16,
  parameter int tag_width  = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  cdb_arbiter_if.slave  bus
);
  localparam int ptr_w = $clog2(num_req);

  logic [ptr_w-1:0]      rr_ptr_r;
  logic                  v_r;
  logic [tag_width-1:0]  tag_r;
  logic [data_width-1:0] data_r;
  logic [ptr_w-1:0]      src_r;

  logic [num_req-1:0]    urg_s;
  logic [num_req-1:0]    cand_s;
  logic [num_req-1:0]    grant_s;
  logic                  found_s;
  logic                  take_s;
  logic [ptr_w-1:0]      win_s;
  logic [ptr_w-1:0]      next_ptr_s;
  logic [tag_width-1:0]  sel_tag_s;
  logic [data_width-1:0] sel_data_s;

  // Candidate selection: scan from rr_ptr with explicit modulo wrap, first hit wins.
  always_comb begin
    int idx;
    idx    = 0;
    urg_s  = bus.req_valid & bus.req_urgent;
    if (urg_s != {num_req{1'b0}}) begin
      cand_s = urg_s;
    end else begin
      cand_s = bus.req_valid;
    end
    found_s = 1'b0;
    win_s   = {ptr_w{1'b0}};
    for (int k = 0; k < num_req; k++) begin
      idx = (int'(rr_ptr_r) + k) % num_req;
      if (!found_s && cand_s[idx]) begin
        found_s = 1'b1;
        win_s   = ptr_w'(idx);
      end else begin
        found_s = found_s;
      end
    end
    take_s  = found_s & ~flush & ~rst;
    grant_s = {num_req{1'b0}};
    if (take_s) begin
      grant_s[win_s] = 1'b1;
    end else begin
      grant_s = {num_req{1'b0}};
    end
    if (win_s == ptr_w'(num_req - 1)) begin
      next_ptr_s = {ptr_w{1'b0}};
    end else begin
      next_ptr_s = win_s + {{(ptr_w-1){1'b0}}, 1'b1};
    end
    sel_tag_s  = bus.req_tag[int'(win_s)*tag_width +: tag_width];
    sel_data_s = bus.req_data[int'(win_s)*data_width +: data_width];
  end

  // Pointer and broadcast register; flush clears the valid but leaves the pointer alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_r <= {ptr_w{1'b0}};
      v_r      <= 1'b0;
      tag_r    <= {tag_width{1'b0}};
      data_r   <= {data_width{1'b0}};
      src_r    <= {ptr_w{1'b0}};
    end else if (flush) begin
      v_r <= 1'b0;
    end else if (found_s) begin
      rr_ptr_r <= next_ptr_s;
      v_r      <= 1'b1;
      tag_r    <= sel_tag_s;
      data_r   <= sel_data_s;
      src_r    <= win_s;
    end else begin
      v_r <= 1'b0;
    end
  end

  assign bus.req_grant = grant_s;
  assign bus.cdb_valid = v_r & ~flush;
  assign bus.cdb_tag   = tag_r;
  assign bus.cdb_data  = data_r;
  assign bus.cdb_src   = src_r;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus randomized traffic
// against a distance-from-pointer reference model.
module tb_cdb_arbiter;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int TW = 3;
  localparam int SW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;

  cdb_arbiter_if #(.num_req(N), .data_width(DW), .tag_width(TW)) bus();

  cdb_arbiter #(.num_req(N), .data_width(DW), .tag_width(TW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [TW-1:0] tag_a [N];
  logic [DW-1:0] data_a [N];

  // reference model state
  int            m_ptr;
  bit            m_pv;
  logic [TW-1:0] m_ptag;
  logic [DW-1:0] m_pdata;
  int            m_psrc;
  int            m_win;
  logic [N-1:0]  exp_grant;
  bit            exp_v;

  task automatic model_reset();
    m_ptr = 0;
    m_pv  = 1'b0;
  endtask

  // Apply inputs, predict grant and broadcast, then move to the sampling edge.
  task automatic drive(input logic [N-1:0] v, input logic [N-1:0] u, input logic f);
    logic [N-1:0] cand;
    int best_d;
    int d;
    bus.req_valid  = v;
    bus.req_urgent = u;
    flush = f;
    for (int i = 0; i < N; i++) begin
      bus.req_tag[i*TW +: TW]  = tag_a[i];
      bus.req_data[i*DW +: DW] = data_a[i];
    end
    cand = ((v & u) != '0) ? (v & u) : v;
    m_win = -1;
    best_d = N;
    for (int i = 0; i < N; i++) begin
      if (cand[i]) begin
        d = (i - m_ptr + N) % N;
        if (d < best_d) begin
          best_d = d;
          m_win = i;
        end
      end
    end
    exp_grant = '0;
    if (!f && m_win >= 0) exp_grant[m_win] = 1'b1;
    exp_v = m_pv && !f;
    @(negedge clk);
  endtask

  task automatic advance();
    @(posedge clk);
    if (exp_grant != '0) begin
      m_pv    = 1'b1;
      m_ptag  = tag_a[m_win];
      m_pdata = data_a[m_win];
      m_psrc  = m_win;
      m_ptr   = (m_win + 1) % N;
    end else begin
      m_pv = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < N; i++) begin
      tag_a[i]  = TW'($urandom);
      data_a[i] = DW'($urandom);
    end
    rst = 1'b1;
    model_reset();
    drive(4'b1111, 4'b0000, 1'b0);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.req_grant !== 4'b0000) begin
      failures++; $display("FAIL reset_grant got=%b exp=0000", bus.req_grant);
    end
    checks++;
    if ({bus.cdb_valid, bus.cdb_tag, bus.cdb_data, bus.cdb_src} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got v=%b tag=%h data=%h src=%0d exp all zero",
               bus.cdb_valid, bus.cdb_tag, bus.cdb_data, bus.cdb_src);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(4'b1111, 4'b0000, 1'b0);
    checks++;
    if (bus.req_grant !== 4'b0001) begin
      failures++; $display("FAIL reset_first_grant got=%b exp=0001", bus.req_grant);
    end
    advance();
    drive(4'b0000, 4'b0000, 1'b0);
    checks++;
    if (bus.cdb_valid !== 1'b1 || bus.cdb_tag !== tag_a[0] || bus.cdb_data !== data_a[0]) begin
      failures++;
      $display("FAIL reset_first_bcast got v=%b tag=%h data=%h exp v=1 tag=%h data=%h",
               bus.cdb_valid, bus.cdb_tag, bus.cdb_data, tag_a[0], data_a[0]);
    end
    advance();
  endtask

  task automatic test_rotation();
    for (int k = 0; k < 9; k++) begin
      drive(4'b1111, 4'b0000, 1'b0);
      checks++;
      if (bus.req_grant !== exp_grant) begin
        failures++; $display("FAIL rot_grant cyc=%0d got=%b exp=%b", k, bus.req_grant, exp_grant);
      end
      checks++;
      if (bus.cdb_valid !== exp_v) begin
        failures++; $display("FAIL rot_valid cyc=%0d got=%b exp=%b", k, bus.cdb_valid, exp_v);
      end
      if (exp_v) begin
        checks++;
        if (bus.cdb_src !== SW'(m_psrc) || bus.cdb_tag !== m_ptag || bus.cdb_data !== m_pdata) begin
          failures++;
          $display("FAIL rot_bcast cyc=%0d got src=%0d tag=%h data=%h exp src=%0d tag=%h data=%h",
                   k, bus.cdb_src, bus.cdb_tag, bus.cdb_data, m_psrc, m_ptag, m_pdata);
        end
      end
      advance();
    end
  endtask

  task automatic test_wrap_skip();
    drive(4'b0100, 4'b0000, 1'b0);
    advance();
    drive(4'b0101, 4'b0000, 1'b0);
    checks++;
    if (bus.req_grant !== 4'b0001 || bus.req_grant !== exp_grant) begin
      failures++; $display("FAIL wrap_grant got=%b exp=0001", bus.req_grant);
    end
    advance();
    drive(4'b0101, 4'b0000, 1'b0);
    checks++;
    if (bus.req_grant !== 4'b0100) begin
      failures++; $display("FAIL skip_grant got=%b exp=0100", bus.req_grant);
    end
    checks++;
    if (bus.cdb_valid !== 1'b1 || bus.cdb_src !== 2'd0) begin
      failures++; $display("FAIL wrap_bcast got v=%b src=%0d exp v=1 src=0", bus.cdb_valid, bus.cdb_src);
    end
    advance();
  endtask

  task automatic test_urgent();
    drive(4'b1000, 4'b0000, 1'b0);
    advance();
    drive(4'b1111, 4'b1000, 1'b0);
    checks++;
    if (bus.req_grant !== 4'b1000) begin
      failures++; $display("FAIL urgent_grant got=%b exp=1000", bus.req_grant);
    end
    advance();
    drive(4'b1111, 4'b0000, 1'b0);
    checks++;
    if (bus.req_grant !== 4'b0001) begin
      failures++; $display("FAIL urgent_after got=%b exp=0001", bus.req_grant);
    end
    advance();
    drive(4'b0110, 4'b1001, 1'b0);
    checks++;
    if (bus.req_grant !== exp_grant) begin
      failures++; $display("FAIL urgent_invalid got=%b exp=%b", bus.req_grant, exp_grant);
    end
    advance();
  endtask

  task automatic test_flush();
    drive(4'b0001, 4'b0000, 1'b0);
    advance();
    tag_a[1]  = 3'd5;
    data_a[1] = 16'hBEEF;
    drive(4'b0010, 4'b0000, 1'b0);
    checks++;
    if (bus.req_grant !== 4'b0010) begin
      failures++; $display("FAIL flush_pre_grant got=%b exp=0010", bus.req_grant);
    end
    advance();
    drive(4'b1111, 4'b0000, 1'b1);
    checks++;
    if (bus.req_grant !== 4'b0000) begin
      failures++; $display("FAIL flush_grant got=%b exp=0000", bus.req_grant);
    end
    checks++;
    if (bus.cdb_valid !== 1'b0) begin
      failures++; $display("FAIL flush_valid got=%b exp=0", bus.cdb_valid);
    end
    advance();
    drive(4'b1111, 4'b0000, 1'b0);
    checks++;
    if (bus.req_grant !== 4'b0100) begin
      failures++; $display("FAIL flush_ptr_hold got=%b exp=0100", bus.req_grant);
    end
    checks++;
    if (bus.cdb_valid !== 1'b0) begin
      failures++; $display("FAIL flush_no_capture got=%b exp=0", bus.cdb_valid);
    end
    advance();
  endtask

  task automatic test_async_reset();
    drive(4'b1111, 4'b0000, 1'b0);
    advance();
    drive(4'b0000, 4'b0000, 1'b0);
    checks++;
    if (bus.cdb_valid !== 1'b1) begin
      failures++; $display("FAIL arst_pre_valid got=%b exp=1", bus.cdb_valid);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.cdb_valid !== 1'b0 || bus.req_grant !== 4'b0000) begin
      failures++; $display("FAIL arst_kill got v=%b grant=%b exp v=0 grant=0000", bus.cdb_valid, bus.req_grant);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    drive(4'b1111, 4'b0000, 1'b0);
    checks++;
    if (bus.req_grant !== 4'b0001) begin
      failures++; $display("FAIL arst_first_grant got=%b exp=0001", bus.req_grant);
    end
    advance();
  endtask

  task automatic test_random();
    logic [N-1:0] v;
    logic [N-1:0] u;
    logic f;
    for (int k = 0; k < 400; k++) begin
      v = N'($urandom);
      u = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      f = ($urandom_range(0, 9) == 0);
      drive(v, u, f);
      checks++;
      if (bus.req_grant !== exp_grant) begin
        failures++; $display("FAIL rnd_grant cyc=%0d got=%b exp=%b", k, bus.req_grant, exp_grant);
      end
      checks++;
      if (bus.cdb_valid !== exp_v) begin
        failures++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", k, bus.cdb_valid, exp_v);
      end
      if (exp_v) begin
        checks++;
        if (bus.cdb_src !== SW'(m_psrc) || bus.cdb_tag !== m_ptag || bus.cdb_data !== m_pdata) begin
          failures++;
          $display("FAIL rnd_bcast cyc=%0d got src=%0d tag=%h data=%h exp src=%0d tag=%h data=%h",
                   k, bus.cdb_src, bus.cdb_tag, bus.cdb_data, m_psrc, m_ptag, m_pdata);
        end
      end
      advance();
      if (m_pv) begin
        tag_a[m_psrc]  = TW'($urandom);
        data_a[m_psrc] = DW'($urandom);
      end
    end
  endtask

  initial begin
    bus.req_valid  = '0;
    bus.req_urgent = '0;
    bus.req_tag    = '0;
    bus.req_data   = '0;
    test_reset();
    test_rotation();
    test_wrap_skip();
    test_urgent();
    test_flush();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Round-robin arbiter for the common data bus (CDB) that carries completed results from the functional units (ALU, load/store unit, branch unit) to the reservation stations and the ROB.
- Grants one requester per cycle and registers the winner's tag and data.
- Broadcasts the registered result for exactly one cycle.
- Honours the commit-stage flush by cancelling in-flight broadcasts.

Parameters:
- num_req, 4, number of functional-unit requesters (2..8)
- data_width, 16, result width
- tag_width, 3, ROB index width

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  commit-stage misprediction flush
- req_valid  in  num_req  requester i has a result pending
- req_urgent  in  num_req  requester i requests priority service (e.g. branch unit); ignored unless req_valid[i]
- req_tag  in  num_req*tag_width  packed ROB tags; slice i = [i*tag_width +: tag_width]
- req_data  in  num_req*data_width  packed results; slice i as above
- req_grant  out  num_req  one-hot grant, combinational; requester i drops or advances its result on the same edge
- cdb_valid  out  1  broadcast valid
- cdb_tag  out  tag_width  broadcast ROB tag
- cdb_data  out  data_width  broadcast value
- cdb_src  out  $clog2(num_req)  index of the broadcasting requester

Behaviour:
- State:
  - rr_ptr ($clog2(num_req) bits), reset 0.
  - Output register {v_q, tag_q, data_q, src_q}, reset all 0.
- Reset:
  - Asynchronous and immediate: cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_src=0, rr_ptr=0.
  - req_grant=0 while rst is high.
  - Reset asserted mid-broadcast kills the broadcast in the same cycle.
- Candidate set:
  - cand = req_valid & req_urgent if that vector is nonzero, else cand = req_valid.
- Selection:
  - Scan indices rr_ptr, rr_ptr+1, ..., wrapping modulo num_req.
  - The first index with cand set wins.
  - req_grant is one-hot on the winner; all zeros if cand=0.
- Grant handshake:
  - A requester holds req_valid, req_tag and req_data stable until it sees req_grant[i]=1 at a rising edge.
  - The grant is consumed on that edge; no separate ready/ack.
- Pointer update:
  - On a grant to index w: rr_ptr <= (w+1) mod num_req.
  - With no grant, rr_ptr holds.
  - The urgent override uses the same pointer, so urgent requesters rotate fairly among themselves.
- Latency:
  - Grant in cycle T gives cdb_valid=1 in cycle T+1, carrying the tag, data and index captured at T.
  - cdb_valid is high for exactly one cycle per grant.
  - Back-to-back grants give a continuous broadcast stream at one result per cycle.
- Flush:
  - While flush=1: req_grant=0, no capture (v_q <= 0), and rr_ptr holds.
  - cdb_valid = v_q & ~flush, so a broadcast in flight during a flush cycle is suppressed in that cycle.
  - The flush owner clears requester state; the arbiter keeps no queue.
- Fairness bound: a requester with req_valid continuously high and no urgent traffic is granted within num_req cycles.
- Starvation by urgent traffic is permitted; bounding it is the requesters' responsibility.
- Simultaneous events:
  - rst dominates flush.
  - Flush dominates all grants.
  - A requester may drop req_valid without a grant (e.g. on flush); there is no penalty and the pointer is unaffected.
- Width rules:
  - num_req not a power of two: the wrap uses explicit modulo, never bit truncation.
  - rr_ptr never holds a value >= num_req.

Test Plan:
- Reset: hold rst=1 with req_valid=4'b1111 -> req_grant=0, cdb_valid=0, rr_ptr=0. Release -> grant 4'b0001 next cycle; cdb_valid=1 one cycle later with tag and data from slice 0.
- Rotation: req_valid=4'b1111, no urgent, 8 cycles -> grant sequence 0,1,2,3,0,1,2,3. cdb_src follows one cycle later. Every cdb_tag and cdb_data matches the granted slice.
- Wrap and skip: rr_ptr=3, req_valid=4'b0101 -> grant index 0. Next cycle, same valid -> grant index 2 (rr_ptr was 1, index 1 idle).
- Urgent: rr_ptr=0, req_valid=4'b1111, req_urgent=4'b1000 -> grant 3; rr_ptr becomes 0. Next cycle, urgent cleared -> grant 0.
- Flush: grant requester 1 in cycle T (tag=5, data=16'hBEEF), flush=1 in T+1 -> cdb_valid=0 in T+1, req_grant=0 in T+1, rr_ptr=2 unchanged across the flush.
- Async reset mid-stream: rst pulsed between edges while cdb_valid=1 -> cdb_valid=0 immediately, without waiting for a clock edge. The first grant after release goes to index 0.
